// File: rtl/grid_io_pkg.sv
// Shared constants and the per-pad config record for the IO grid tile.
package grid_io_pkg;

    localparam int CFG_BITS_PER_PAD = 2;
    localparam int OE_BIT           = 0;
    localparam int IREG_BIT         = 1;

    // Field order matches the chain layout: bit 0 = oe, bit 1 = ireg.
    typedef struct packed {
        logic ireg;
        logic oe;
    } pad_cfg_t;

endpackage

// File: rtl/grid_io_pad_cell.sv
// One IO pad: output drive gating, input sampling register and input mux.
module grid_io_pad_cell
    import grid_io_pkg::*;
(
    input  logic     prog_clk,
    input  logic     prog_reset,
    input  pad_cfg_t cfg,
    input  logic     outpad,
    input  logic     pad_in,
    output logic     pad_out,
    output logic     pad_oe,
    output logic     inpad
);

    logic in_q;

    // Pad input is sampled every edge regardless of mode, so switching to
    // registered mode never exposes a stale value.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) in_q <= 1'b0;
        else            in_q <= pad_in;
    end

    // Output pads read back 0 to the fabric; inputs pick registered or direct.
    always_comb begin
        pad_oe  = cfg.oe;
        pad_out = cfg.oe & outpad;
        inpad   = 1'b0;
        if (!cfg.oe) inpad = cfg.ireg ? in_q : pad_in;
    end

endmodule

// File: rtl/grid_io_cfg_tile.sv
// IO grid tile: serial config chain with shadow/active split plus NUM_PADS pads.
module grid_io_cfg_tile
    import grid_io_pkg::*;
#(
    parameter int NUM_PADS = 8
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic [NUM_PADS-1:0] outpad,
    output logic [NUM_PADS-1:0] inpad,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic [NUM_PADS-1:0] pad_out,
    output logic [NUM_PADS-1:0] pad_oe
);

    localparam int CHAIN_LEN = CFG_BITS_PER_PAD * NUM_PADS;
    // Counter must reach CHAIN_LEN+1 to flag an over-shift.
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] shadow_q;
    logic [CHAIN_LEN-1:0] active_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;
    logic                 commit_ok;

    assign cfg_done  = (cnt_q == CNT_FULL);
    assign commit_ok = cfg_commit & cfg_done & ~ccff_en;
    assign ccff_tail = shadow_q[CHAIN_LEN-1];
    assign cfg_err   = err_q;

    // Shadow chain shifts toward the tail; holds when not enabled.
    always_ff @(posedge prog_clk) begin
        if (prog_reset)   shadow_q <= '0;
        else if (ccff_en) shadow_q <= {shadow_q[CHAIN_LEN-2:0], ccff_head};
    end

    // Shift counter: saturates one past full so over-shifting drops cfg_done.
    always_ff @(posedge prog_clk) begin
        if (prog_reset)                      cnt_q <= '0;
        else if (commit_ok)                  cnt_q <= '0;
        else if (ccff_en && cnt_q != CNT_OVER) cnt_q <= cnt_q + 1'b1;
    end

    // Active config only moves on an accepted commit, so pads stay quiet while shifting.
    always_ff @(posedge prog_clk) begin
        if (prog_reset)     active_q <= '0;
        else if (commit_ok) active_q <= shadow_q;
    end

    // Any commit attempt that is not accepted latches the error until reset.
    always_ff @(posedge prog_clk) begin
        if (prog_reset)                   err_q <= 1'b0;
        else if (cfg_commit && !commit_ok) err_q <= 1'b1;
    end

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        grid_io_pad_cell u_pad (
            .prog_clk   (prog_clk),
            .prog_reset (prog_reset),
            .cfg        (pad_cfg_t'(active_q[CFG_BITS_PER_PAD*i +: CFG_BITS_PER_PAD])),
            .outpad     (outpad[i]),
            .pad_in     (pad_in[i]),
            .pad_out    (pad_out[i]),
            .pad_oe     (pad_oe[i]),
            .inpad      (inpad[i])
        );
    end

endmodule

// File: tb/tb_grid_io_cfg_tile.sv
// Randomized self-checking bench for grid_io_cfg_tile against a behavioural model.
module tb_grid_io_cfg_tile;

    localparam int NP = 8;
    localparam int CL = 16;

    logic          prog_clk = 1'b0;
    logic          prog_reset, ccff_head, ccff_en, cfg_commit;
    logic          ccff_tail, cfg_done, cfg_err;
    logic [NP-1:0] outpad, inpad, pad_in, pad_out, pad_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [CL-1:0] m_sh, m_act;
    int            m_cnt;
    logic [NP-1:0] m_inq;
    logic          m_err;

    grid_io_cfg_tile #(.NUM_PADS(NP)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .ccff_head  (ccff_head),
        .ccff_en    (ccff_en),
        .cfg_commit (cfg_commit),
        .ccff_tail  (ccff_tail),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .outpad     (outpad),
        .inpad      (inpad),
        .pad_in     (pad_in),
        .pad_out    (pad_out),
        .pad_oe     (pad_oe)
    );

    always #5 prog_clk = ~prog_clk;

    function automatic logic [NP-1:0] e_oe();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = m_act[2*i];
        return r;
    endfunction

    function automatic logic [NP-1:0] e_in();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++)
            r[i] = m_act[2*i] ? 1'b0 : (m_act[2*i+1] ? m_inq[i] : pad_in[i]);
        return r;
    endfunction

    // One clock edge; model advances from the inputs present at the edge.
    task automatic tick();
        @(posedge prog_clk);
        if (prog_reset) begin
            m_sh = '0; m_act = '0; m_cnt = 0; m_inq = '0; m_err = 1'b0;
        end else begin
            if (cfg_commit) begin
                if (m_cnt == CL && !ccff_en) begin m_act = m_sh; m_cnt = 0; end
                else m_err = 1'b1;
            end
            if (ccff_en) begin
                m_sh  = CL'((int'(m_sh) * 2) + int'(ccff_head));
                m_cnt = (m_cnt + 1 > CL + 1) ? CL + 1 : m_cnt + 1;
            end
            m_inq = pad_in;
        end
        #1;
    endtask

    // Shift the low n bits of w, most significant first.
    task automatic shift_word(input logic [CL-1:0] w, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            ccff_en = 1'b1; ccff_head = w[k];
            tick();
        end
        ccff_en = 1'b0; ccff_head = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset = 1'b1; ccff_en = 1'b1; cfg_commit = 1'b1; ccff_head = 1'b1;
        tick();
        prog_reset = 1'b0; ccff_en = 1'b0; cfg_commit = 1'b0; ccff_head = 1'b0;
        pad_in = 8'hA5; outpad = 8'hFF;
        #1;
        n_checks++; if (ccff_tail !== 1'b0) begin n_fail++; $display("FAIL reset_tail got %b exp 0", ccff_tail); end
        n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", cfg_done); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", cfg_err); end
        n_checks++; if (pad_oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe got %h exp 00", pad_oe); end
        n_checks++; if (pad_out !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h exp 00", pad_out); end
        n_checks++; if (inpad !== 8'hA5) begin n_fail++; $display("FAIL reset_inpad got %h exp a5", inpad); end
    endtask

    task automatic test_load_oe_ireg();
        shift_word(16'h0003, 16);
        n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL load_done_pre got %b exp 1", cfg_done); end
        commit();
        n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL load_done_post got %b exp 0", cfg_done); end
        n_checks++; if (pad_oe !== 8'h01) begin n_fail++; $display("FAIL load_oe got %h exp 01", pad_oe); end
        for (int k = 0; k < 4; k++) begin
            outpad = 8'($urandom); pad_in = 8'($urandom);
            #1;
            n_checks++; if (pad_out !== {7'h0, outpad[0]}) begin n_fail++; $display("FAIL load_out got %h exp %h", pad_out, {7'h0, outpad[0]}); end
            n_checks++; if (inpad[0] !== 1'b0) begin n_fail++; $display("FAIL load_inpad0 got %b exp 0", inpad[0]); end
            tick();
        end
    endtask

    task automatic test_ireg();
        logic [NP-1:0] p;
        shift_word(16'h0002, 16);
        commit();
        n_checks++; if (pad_oe !== 8'h00) begin n_fail++; $display("FAIL ireg_oe got %h exp 00", pad_oe); end
        pad_in = 8'h00;
        tick();
        for (int k = 0; k < 4; k++) begin
            p = 8'($urandom); p[0] = ~pad_in[0];
            pad_in = p;
            #1;
            n_checks++; if (inpad[0] !== ~p[0]) begin n_fail++; $display("FAIL ireg_delay got %b exp %b", inpad[0], ~p[0]); end
            n_checks++; if (inpad[7:1] !== p[7:1]) begin n_fail++; $display("FAIL ireg_pass got %h exp %h", inpad[7:1], p[7:1]); end
            tick();
            n_checks++; if (inpad[0] !== p[0]) begin n_fail++; $display("FAIL ireg_follow got %b exp %b", inpad[0], p[0]); end
        end
    endtask

    task automatic test_short_commit();
        shift_word(16'h0005 >> 1, 15);
        commit();
        n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL short_err got %b exp 1", cfg_err); end
        n_checks++; if (pad_oe !== 8'h00) begin n_fail++; $display("FAIL short_oe got %h exp 00", pad_oe); end
        shift_word(16'h0005, 1);
        n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL short_done got %b exp 1", cfg_done); end
        commit();
        n_checks++; if (pad_oe !== 8'h03) begin n_fail++; $display("FAIL short_accept got %h exp 03", pad_oe); end
        n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL short_err_sticky got %b exp 1", cfg_err); end
    endtask

    task automatic test_over_shift();
        do_reset();
        shift_word(16'($urandom), 16);
        n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL over_done16 got %b exp 1", cfg_done); end
        shift_word(16'h0001, 1);
        n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL over_done17 got %b exp 0", cfg_done); end
        commit();
        n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL over_err got %b exp 1", cfg_err); end
        n_checks++; if (pad_oe !== 8'h00) begin n_fail++; $display("FAIL over_oe got %h exp 00", pad_oe); end
    endtask

    task automatic test_no_glitch();
        logic [CL-1:0] prior, nw;
        do_reset();
        shift_word(16'h5555, 16);
        commit();
        prior = 16'h5555;
        nw = 16'($urandom);
        n_checks++; if (ccff_tail !== prior[15]) begin n_fail++; $display("FAIL glitch_tail0 got %b exp %b", ccff_tail, prior[15]); end
        for (int k = 1; k <= 16; k++) begin
            ccff_en = 1'b1; ccff_head = nw[16-k]; outpad = 8'($urandom);
            tick();
            n_checks++; if (pad_oe !== 8'hFF) begin n_fail++; $display("FAIL glitch_oe got %h exp ff", pad_oe); end
            n_checks++; if (pad_out !== outpad) begin n_fail++; $display("FAIL glitch_out got %h exp %h", pad_out, outpad); end
            if (k < 16) begin
                n_checks++; if (ccff_tail !== prior[15-k]) begin n_fail++; $display("FAIL glitch_tail got %b exp %b", ccff_tail, prior[15-k]); end
            end else begin
                n_checks++; if (ccff_tail !== nw[15]) begin n_fail++; $display("FAIL glitch_tail_new got %b exp %b", ccff_tail, nw[15]); end
            end
        end
        ccff_en = 1'b0;
        commit();
        n_checks++; if (pad_oe !== e_oe()) begin n_fail++; $display("FAIL glitch_commit got %h exp %h", pad_oe, e_oe()); end
    endtask

    task automatic test_reset_mid_shift();
        shift_word(16'hFFFF, 8);
        prog_reset = 1'b1; ccff_en = 1'b1; ccff_head = 1'b1; cfg_commit = 1'b1;
        tick();
        prog_reset = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
        pad_in = 8'h3C; outpad = 8'hFF;
        #1;
        n_checks++; if (ccff_tail !== 1'b0) begin n_fail++; $display("FAIL mid_tail got %b exp 0", ccff_tail); end
        n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b exp 0", cfg_done); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL mid_err got %b exp 0", cfg_err); end
        n_checks++; if (pad_oe !== 8'h00) begin n_fail++; $display("FAIL mid_oe got %h exp 00", pad_oe); end
        n_checks++; if (pad_out !== 8'h00) begin n_fail++; $display("FAIL mid_out got %h exp 00", pad_out); end
        n_checks++; if (inpad !== 8'h3C) begin n_fail++; $display("FAIL mid_inpad got %h exp 3c", inpad); end
        shift_word(16'h00C3, 16);
        n_checks++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL mid_reload_done got %b exp 1", cfg_done); end
        commit();
        n_checks++; if (pad_oe !== 8'h09) begin n_fail++; $display("FAIL mid_reload_oe got %h exp 09", pad_oe); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL mid_reload_err got %b exp 0", cfg_err); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            pad_in = 8'($urandom); outpad = 8'($urandom);
            ccff_head = 1'($urandom);
            if (m_cnt == CL) begin
                cfg_commit = 1'($urandom);
                ccff_en    = ($urandom_range(2) == 0);
            end else begin
                cfg_commit = ($urandom_range(15) == 0);
                ccff_en    = ($urandom_range(3) != 0);
            end
            prog_reset = ($urandom_range(199) == 0);
            #1;
            n_checks++; if (pad_oe !== e_oe()) begin n_fail++; $display("FAIL rnd_oe cyc %0d got %h exp %h", c, pad_oe, e_oe()); end
            n_checks++; if (pad_out !== (outpad & e_oe())) begin n_fail++; $display("FAIL rnd_out cyc %0d got %h exp %h", c, pad_out, outpad & e_oe()); end
            n_checks++; if (inpad !== e_in()) begin n_fail++; $display("FAIL rnd_inpad cyc %0d got %h exp %h", c, inpad, e_in()); end
            n_checks++; if (ccff_tail !== m_sh[CL-1]) begin n_fail++; $display("FAIL rnd_tail cyc %0d got %b exp %b", c, ccff_tail, m_sh[CL-1]); end
            n_checks++; if (cfg_done !== (m_cnt == CL)) begin n_fail++; $display("FAIL rnd_done cyc %0d got %b exp %b", c, cfg_done, m_cnt == CL); end
            n_checks++; if (cfg_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b exp %b", c, cfg_err, m_err); end
            tick();
        end
        prog_reset = 1'b0; ccff_en = 1'b0; cfg_commit = 1'b0;
    endtask

    initial begin
        prog_reset = 1'b1; ccff_head = 1'b0; ccff_en = 1'b0; cfg_commit = 1'b0;
        outpad = '0; pad_in = '0;
        m_sh = '0; m_act = '0; m_cnt = 0; m_inq = '0; m_err = 1'b0;
        test_reset();
        test_load_oe_ireg();
        test_ireg();
        test_short_commit();
        test_over_shift();
        test_no_glitch();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
